// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle signed restoring divider, one quotient bit per
//                clock, with a one-cycle ready pulse and divide-by-zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [c_CW-1:0]  r_count;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_div_zero;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_shift_rem;
    logic [WIDTH:0]   w_diff;

    // Negating -2^(W-1) wraps to itself, which read unsigned is exactly its magnitude.
    assign w_abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign w_shift_rem = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_diff      = {1'b0, w_shift_rem} - {1'b0, r_divisor};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_quo          <= '0;
            r_rem          <= '0;
            r_divisor      <= '0;
            r_count        <= '0;
            r_sign_a       <= 1'b0;
            r_sign_b       <= 1'b0;
            r_div_zero     <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_div) begin
                // A new start always wins, silently dropping any operation in flight.
                r_sign_a   <= data_operandA[WIDTH-1];
                r_sign_b   <= data_operandB[WIDTH-1];
                r_quo      <= w_abs_a;
                r_divisor  <= w_abs_b;
                r_rem      <= '0;
                r_count    <= '0;
                r_div_zero <= (data_operandB == '0);
                busy       <= 1'b1;
                r_state    <= (data_operandB == '0) ? S_DONE : S_RUN;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_quo   <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
                        r_rem   <= w_diff[WIDTH] ? w_shift_rem : w_diff[WIDTH-1:0];
                        r_count <= r_count + c_ONE;
                        if (r_count == c_LAST) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (r_div_zero) begin
                            data_result    <= '0;
                            data_remainder <= '0;
                            data_exception <= 1'b1;
                        end else begin
                            data_result    <= (r_sign_a ^ r_sign_b) ? -r_quo : r_quo;
                            data_remainder <= r_sign_a ? -r_rem : r_rem;
                            data_exception <= 1'b0;
                        end
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Directed and random checks of seq_divider against a 64-bit
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             ctrl_div;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: signed division in 64 bits, truncated to WIDTH bits.
    task automatic ref_div(input logic [31:0] av, input logic [31:0] bv,
                           output logic [31:0] eq, output logic [31:0] er,
                           output logic ex, output int lat);
        longint la, lb, lq, lr;
        if (bv == 32'd0) begin
            eq = 32'd0; er = 32'd0; ex = 1'b1; lat = 1;
        end else begin
            la = longint'($signed(av));
            lb = longint'($signed(bv));
            lq = la / lb;
            lr = la % lb;
            eq = lq[31:0];
            er = lr[31:0];
            ex = 1'b0;
            lat = WIDTH + 1;
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
        ctrl_div      = 1'b1;
        data_operandA = av;
        data_operandB = bv;
        @(posedge clock);
        @(negedge clock);
        ctrl_div = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_and_check(input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] eq, er;
        logic        ex;
        int          lat, edges;
        logic        saw, moved;
        logic [31:0] prev_res, prev_rem;
        ref_div(av, bv, eq, er, ex, lat);
        prev_res = data_result;
        prev_rem = data_remainder;
        start_op(av, bv);
        edges = 0; saw = 1'b0; moved = 1'b0;
        while (!saw && edges < 40) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (data_resultRDY) saw = 1'b1;
            else if (data_result !== prev_res || data_remainder !== prev_rem) moved = 1'b1;
        end
        if (!saw) edges = -1;
        check("latency", edges, lat);
        check("outputs_stable_while_busy", {31'd0, moved}, 32'd0);
        check("result", data_result, eq);
        check("remainder", data_remainder, er);
        check("exception", {31'd0, data_exception}, {31'd0, ex});
        check("busy_at_rdy", {31'd0, busy}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("rdy_single_pulse", {31'd0, data_resultRDY}, 32'd0);
        check("result_held", data_result, eq);
    endtask

    initial begin
        int          spurious;
        logic [31:0] ra, rb;
        reset_n       = 1'b0;
        ctrl_div      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_remainder", data_remainder, 32'd0);
        check("reset_exception", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run_and_check(32'd7, 32'd2);
        run_and_check(32'hFFFF_FFF9, 32'd2);
        run_and_check(32'd7, 32'hFFFF_FFFE);
        run_and_check(32'd100, 32'd0);
        run_and_check(32'h8000_0000, 32'hFFFF_FFFF);
        run_and_check(32'd5, 32'd9);
        run_and_check(32'h8000_0000, 32'h8000_0000);
        run_and_check(32'h7FFF_FFFF, 32'h8000_0000);

        // Restart mid-operation: only the second start may report.
        spurious = 0;
        start_op(32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) spurious++;
        end
        run_and_check(32'd50, 32'd7);
        check("no_rdy_for_aborted_op", spurious, 32'd0);

        // Asynchronous reset mid-operation.
        spurious = 0;
        start_op(32'd1000, 32'd3);
        for (int i = 0; i < 14; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) spurious++;
        end
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_result", data_result, 32'd0);
        check("async_reset_remainder", data_remainder, 32'd0);
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        check("async_reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) spurious++;
        end
        check("no_rdy_after_reset_abort", spurious, 32'd0);
        run_and_check(32'd9, 32'd3);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 15);
                2: rb = -$urandom_range(1, 15);
                default: rb = $urandom_range(0, 20) - 32'd10;
            endcase
            run_and_check(ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
